hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. It produces the per-cycle enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It covers load-use hazards, taken-branch flushes and variable-latency data-memory accesses through a req/ready handshake. It sits beside the pipeline registers, takes hazard information from the ID/EX and EX/MEM stages, and owns the only state machine that freezes the pipeline.

## Interface
- MEM_TIMEOUT, default 16: consecutive non-ready cycles of a memory access before a fatal timeout (legal 1..255).
- CNT_W, default 32: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination register of the load in EX.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- branch_taken  in  1  branch resolved taken this cycle.
- exmem_memread, exmem_memwrite  in  1 each  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  load a NOP/bubble instead of upstream data.
- memwb_bubble  out  1  forces MemREG/RegWRITE into MEM/WB to 0.
- mem_req  out  1  access request to data memory.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.

## Operation
- States: RUN, MEM_WAIT, ERROR. The wait counter wait_cnt spans 0..MEM_TIMEOUT.
- mem_acc = exmem_memread | exmem_memwrite.
- mem_req = mem_acc in RUN or MEM_WAIT; mem_req = 0 in ERROR.
- Default outputs: all enables 1, flushes 0, bubble 0.
- Priority 1, memory stall, when mem_req=1 and mem_ready=0:
  - pc_en, ifid_en and exmem_en go to 0; no flush occurs.
  - memwb_en=1 with memwb_bubble=1, so WB does not repeat a write.
  - branch_taken and the load-use check are ignored. The upstream stages are frozen, so those conditions persist to the release cycle.
- Priority 2, taken branch: ifid_flush=1, idex_flush=1, pc_en=1.
- Priority 3, load-use hazard, when idex_memread & idex_rt≠0 & (idex_rt==ifid_rs | idex_rt==ifid_rt): pc_en=0, ifid_en=0, idex_flush=1.
- FSM transitions:
  - RUN: if mem_req & !mem_ready, go to MEM_WAIT with wait_cnt=1. Otherwise stay in RUN.
  - MEM_WAIT with mem_ready=1: return to RUN, wait_cnt=0.
  - MEM_WAIT with mem_ready=0: if wait_cnt==MEM_TIMEOUT, go to ERROR; else increment wait_cnt.
  - MEM_WAIT when mem_acc drops without ready (protocol violation): return to RUN.
  - ERROR: all enables 0, flushes 0, memwb_bubble=1, mem_req=0, mem_err=1. Only reset exits ERROR.
- stall_cnt increments on every rising edge where pc_en=0, including ERROR cycles. It holds at 2^CNT_W−1.

## Timing
- Reset assertion, asynchronous:
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
  - While rst_n=0, combinational outputs are forced to: enables 0, flushes 0, memwb_bubble=1, mem_req=0.
- Reset release: outputs follow the normal rules in the same cycle.
- Reset during MEM_WAIT or ERROR returns to RUN immediately; no access is completed.
- All control outputs except mem_err and stall_cnt are combinational from state and inputs, valid in the same cycle.
- Zero-wait memory (mem_ready=1 in the first request cycle) adds 0 stall cycles.
- N wait cycles (N ≤ MEM_TIMEOUT) add exactly N frozen cycles.
- The release cycle is the one where mem_ready=1. In it, all enables are 1 and a pending branch or load-use decision applies.
- Load-use adds exactly 1 bubble, since the stalled load advances and the hazard clears the next cycle.
- Timeout: mem_err rises on the edge ending the (MEM_TIMEOUT+1)-th consecutive non-ready request cycle.
- Simultaneous branch_taken and load-use: the branch wins, there is no stall, and both ID and EX are flushed.

## Test plan
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle. With idex_rt=0 → no stall.
- Branch plus hazard in the same cycle: branch_taken=1 with a load-use match → ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- Memory wait: exmem_memread=1 with mem_ready low for 3 cycles, then high:
  - 3 cycles of pc_en=exmem_en=0 with memwb_bubble=1.
  - mem_req high for 4 cycles.
  - stall_cnt +3, state back to RUN.
- Timeout with MEM_TIMEOUT=4 and mem_ready held 0 → mem_err=1 after the 5th non-ready edge. All enables stay 0 and mem_req=0 until rst_n low.
- Reset mid-wait: drop rst_n during MEM_WAIT → mem_req=0 and enables 0 immediately. After release, stall_cnt=0 and state is RUN.
- Saturation with CNT_W=4: hold a load-use stall for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath: load-use stalls,
// taken-branch flushes and memory-wait freezes, plus a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             branch_taken,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t     state, nextState;
  logic [7:0] waitCnt, nextWait;
  logic       memAcc, loadUse;

  assign memAcc   = exmem_memread | exmem_memwrite;
  assign loadUse  = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  assign dbgState = state;

  // Memory-side handshake: mem_req/mem_ready. An access is in flight while
  // mem_req=1; it completes in the cycle mem_ready=1, and every cycle with
  // mem_req=1 and mem_ready=0 freezes the pipeline upstream of MEM/WB.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_req      = memAcc && (state != ERROR);
    if (!rst_n || state == ERROR) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
      mem_req      = 1'b0;
    end else if (mem_req && !mem_ready) begin
      // MEM/WB keeps loading, but with a bubble so WB never repeats a write.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (loadUse) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    nextWait  = waitCnt;
    case (state)
      RUN: begin
        if (memAcc && !mem_ready) begin
          nextState = MEM_WAIT;
          nextWait  = 8'd1;
        end
      end
      MEM_WAIT: begin
        // Dropping the access without ready is a protocol violation: abandon it.
        if (!memAcc || mem_ready) begin
          nextState = RUN;
          nextWait  = 8'd0;
        end else if (waitCnt == 8'(MEM_TIMEOUT)) begin
          nextState = ERROR;
        end else begin
          nextWait  = waitCnt + 8'd1;
        end
      end
      ERROR:   nextState = ERROR;
      default: begin
        nextState = RUN;
        nextWait  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      waitCnt   <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWait;
      mem_err <= mem_err | (nextState == ERROR);
      if (!pc_en && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl: the driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam logic [1:0] ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_ERR = 2'd2;
  localparam logic [3:0] EN_ALL = 4'b1111, EN_LU = 4'b0011, EN_MEM = 4'b0001, EN_NONE = 4'b0000;
  localparam logic [1:0] F_NONE = 2'b00, F_BR = 2'b11, F_LU = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic idex_memread = 1'b0;
  logic [4:0] idex_rt = 5'd0, ifid_rs = 5'd0, ifid_rt = 5'd0;
  logic branch_taken = 1'b0, exmem_memread = 1'b0, exmem_memwrite = 1'b0, mem_ready = 1'b0;
  logic pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble, mem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] dbg_state;

  logic [14:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .branch_taken(branch_taken), .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_req(mem_req), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .dbgState(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [14:0] mk(input logic [3:0] en, input logic [1:0] fl,
                                     input logic bub, input logic req, input logic err,
                                     input logic [3:0] cnt, input logic [1:0] st);
    return {en, fl, bub, req, err, cnt, st};
  endfunction

  // Driver: one call is one clock cycle of inputs plus its expected response.
  task automatic step(input string nm, input logic r, input logic mr, input logic [4:0] rt,
                      input logic [4:0] rs, input logic [4:0] rt2, input logic br,
                      input logic emr, input logic emw, input logic rdy, input logic [14:0] e);
    @(posedge clk);
    #1;
    rst_n          = r;
    idex_memread   = mr;
    idex_rt        = rt;
    ifid_rs        = rs;
    ifid_rt        = rt2;
    branch_taken   = br;
    exmem_memread  = emr;
    exmem_memwrite = emw;
    mem_ready      = rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [14:0] e, got;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             memwb_bubble, mem_req, mem_err, stall_cnt, dbg_state};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got en=%b fl=%b bub=%b req=%b err=%b cnt=%0d st=%0d, exp en=%b fl=%b bub=%b req=%b err=%b cnt=%0d st=%0d",
                 nm, got[14:11], got[10:9], got[8], got[7], got[6], got[5:2], got[1:0],
                 e[14:11], e[10:9], e[8], e[7], e[6], e[5:2], e[1:0]);
      end
    end
  end

  initial begin
    //    name          rst mr rt     rs     rt2    br emr emw rdy
    step("reset",       0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_NONE, F_NONE, 1, 0, 0, 0, ST_RUN));
    step("idle",        1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 0, ST_RUN));
    step("lu_rs",       1, 1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, mk(EN_LU, F_LU, 0, 0, 0, 0, ST_RUN));
    step("lu_clear",    1, 0, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 1, ST_RUN));
    step("lu_r0",       1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 1, ST_RUN));
    step("lu_rt",       1, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, mk(EN_LU, F_LU, 0, 0, 0, 1, ST_RUN));
    step("br_lu",       1, 1, 5'd8, 5'd8, 5'd2, 1, 0, 0, 0, mk(EN_ALL, F_BR, 0, 0, 0, 2, ST_RUN));
    step("br_only",     1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, mk(EN_ALL, F_BR, 0, 0, 0, 2, ST_RUN));
    // three non-ready cycles, then release with a branch pending
    step("mw1",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 2, ST_RUN));
    step("mw2_br",      1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 3, ST_WAIT));
    step("mw3_lu",      1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 4, ST_WAIT));
    step("mw_release",  1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, mk(EN_ALL, F_BR, 0, 1, 0, 5, ST_WAIT));
    step("mw_after",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 5, ST_RUN));
    step("zero_wait",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, mk(EN_ALL, F_NONE, 0, 1, 0, 5, ST_RUN));
    step("zw_after",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 5, ST_RUN));
    // access withdrawn without ready
    step("pv_stall",    1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 5, ST_RUN));
    step("pv_drop",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 6, ST_WAIT));
    step("pv_run",      1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 6, ST_RUN));
    // timeout: error on the edge ending the 5th non-ready cycle
    step("to1",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 6, ST_RUN));
    step("to2",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 7, ST_WAIT));
    step("to3",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 8, ST_WAIT));
    step("to4",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 9, ST_WAIT));
    step("to5",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 10, ST_WAIT));
    step("err_rdy_br",  1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 1, mk(EN_NONE, F_NONE, 1, 0, 1, 11, ST_ERR));
    step("err_idle",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_NONE, F_NONE, 1, 0, 1, 12, ST_ERR));
    step("err_reset",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_NONE, F_NONE, 1, 0, 0, 0, ST_RUN));
    step("post_reset",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 0, ST_RUN));
    // reset in the middle of a memory wait
    step("rw1",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 0, ST_RUN));
    step("rw2",         1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_MEM, F_NONE, 1, 1, 0, 1, ST_WAIT));
    step("rw_reset",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, mk(EN_NONE, F_NONE, 1, 0, 0, 0, ST_RUN));
    step("rw_release",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 0, ST_RUN));
    // held load-use stall saturates the 4-bit counter at 15
    for (int i = 0; i < 20; i++) begin
      logic [3:0] c;
      c = (i > 15) ? 4'd15 : 4'(i);
      step("sat", 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, mk(EN_LU, F_LU, 0, 0, 0, c, ST_RUN));
    end
    step("sat_hold",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, mk(EN_ALL, F_NONE, 0, 0, 0, 15, ST_RUN));
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d unchecked entries, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
